mem_arbiter: RTL
================

# mem_arbiter

Arbitrates one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage pipeline. Each access is sequenced through a small FSM, read data is registered back to the winner, and a combinational `MemStall` is raised, which the hazard unit ORs into its stall/freeze logic so the whole pipeline holds while any access is outstanding. Data requests take priority over fetch.

## Interface
- `XLEN`, 32: data and address width.
- `LATENCY`, 1: memory read latency in cycles, counted from the `mem_req` cycle to the cycle `mem_rdata` is valid. Legal range is 1–15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  in  1  fetch requests a read; held until `imem_ready`, or dropped to abandon.
- `imem_addr`  in  XLEN  fetch address.
- `imem_ready`  out  1  one-cycle pulse; `imem_rdata` valid.
- `imem_rdata`  out  XLEN  fetched word.
- `dmem_req`  in  1  memory-stage request; must be held until `dmem_ready`.
- `dmem_we`  in  1  1 = store, 0 = load.
- `dmem_addr`  in  XLEN  data address.
- `dmem_wdata`  in  XLEN  store data.
- `dmem_wmask`  in  XLEN/8  byte-enable mask for stores.
- `dmem_ready`  out  1  one-cycle pulse; access complete, `dmem_rdata` valid for loads.
- `dmem_rdata`  out  XLEN  loaded word.
- `mem_req`  out  1  one-cycle access strobe to memory.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/XLEN/XLEN/XLEN/8  registered copies of the granted request.
- `mem_rdata`  in  XLEN  valid exactly `LATENCY` cycles after the `mem_req` cycle.
- `MemStall`  out  1  `(imem_req & ~imem_ready) | (dmem_req & ~dmem_ready)`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. A 4-bit counter `cnt` tracks the wait.
- IDLE:
  - If `dmem_req` is high, grant data (`gnt_d=1`). Else if `imem_req` is high, grant fetch (`gnt_d=0`).
  - On a grant, register the winner's `we`/`addr`/`wdata`/`wmask` into the `mem_*` registers. Fetch always registers `we=0` and `wmask=0`.
  - On a grant: next state ISSUE, `cnt←LATENCY`, `abandon←0`.
- ISSUE: `mem_req=1` for this one cycle only; next state WAIT.
- WAIT:
  - `cnt` decrements each cycle.
  - In the cycle `cnt==1`, `mem_rdata` is valid. At that edge, capture it into `dmem_rdata` (data load) or `imem_rdata` (fetch), then go to DONE.
  - Stores do not update `dmem_rdata`.
- DONE:
  - Pulse the winner's ready signal. Fetch ready is suppressed if `abandon==1`.
  - No grant is made in DONE, so a requester still holding `req` in its ready cycle is never re-granted.
  - Next state IDLE.
- Abandon: in ISSUE or WAIT with `gnt_d==0`, if `imem_req==0` in any cycle, set `abandon←1`. The memory access still completes; `imem_rdata` is not updated and `imem_ready` stays 0.
- Dropping `dmem_req` before ready is a protocol violation. The access (including a write) completes anyway and `dmem_ready` still pulses.
- Both requests high in IDLE: data wins. Fetch is granted at the next IDLE cycle, after DONE.
- Reset values:
  - State IDLE, `cnt=0`, `abandon=0`.
  - All `mem_*` outputs 0.
  - `imem_ready=dmem_ready=0`, `imem_rdata=dmem_rdata=0`.
  - `MemStall` follows its equation from the inputs.
- Reset mid-access: the FSM is in IDLE the cycle after the reset edge. Any in-flight `mem_rdata` is ignored, no ready pulses, and no second `mem_req`.

## Timing
- The request is first seen in IDLE at cycle T.
- `mem_req` is high at T+1.
- `mem_rdata` is sampled at T+1+LATENCY.
- Ready is high at T+2+LATENCY.
- IDLE is reached again at T+3+LATENCY.
- Occupancy is LATENCY+3 cycles per access; with LATENCY=1, ready arrives at T+3.
- The ready outputs are registered. `MemStall` is combinational and drops in the ready cycle, so the pipeline advances on that edge.
- Back-to-back accesses from one requester: the next `mem_req` is no earlier than 3+LATENCY cycles after the previous one.

## Test plan
1. **Single fetch, LATENCY=1.**
   - Stimulus: `imem_req=1` with `imem_addr=0x100` at T; the memory model returns `0xDEADBEEF`.
   - Required: `mem_req` at T+1 with `mem_addr=0x100` and `mem_we=0`; `imem_ready` with `imem_rdata=0xDEADBEEF` at T+3; `MemStall` high for T..T+2 and low at T+3.
2. **Store.**
   - Stimulus: `dmem_req=1`, `we=1`, addr `0x2000`, wdata `0x12345678`, wmask `0xF`.
   - Required: one `mem_req` with those values; `dmem_ready` at T+3; `dmem_rdata` stays 0.
3. **Simultaneous requests.**
   - Stimulus: fetch `0x104` and load `0x2004` both raised at T.
   - Required: data is issued at T+1 and `dmem_ready` pulses at T+3; fetch `mem_req` at T+5 and `imem_ready` at T+7.
4. **Abandon.**
   - Stimulus: fetch granted at T; `imem_req` dropped at T+2.
   - Required: `mem_req` still pulses exactly once; no `imem_ready` pulse; `imem_rdata` unchanged; a `dmem_req` raised at T+3 is granted in the IDLE cycle T+4.
5. **LATENCY=4 and reset mid-access.**
   - Required: the first load is ready at T+6. For a second load, asserting `reset` in its WAIT phase gives all outputs 0 on the next cycle, no ready pulse, and the state is IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported fixed-latency unified memory shared by fetch and
// the memory stage. Data requests win; each access runs IDLE->ISSUE->WAIT->DONE.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_req,
    input  logic [XLEN-1:0]   imem_addr,
    output logic              imem_ready,
    output logic [XLEN-1:0]   imem_rdata,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wmask,
    output logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              MemStall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_gnt_d;
    logic                r_abandon;
    logic                w_grant;
    logic                w_grant_d;
    logic                w_capture;
    logic                w_abandon_nxt;

    logic                r_imem_ready;
    logic [XLEN-1:0]     r_imem_rdata;
    logic                r_dmem_ready;
    logic [XLEN-1:0]     r_dmem_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;
    logic [XLEN/8-1:0]   r_mem_wmask;

    // Next-state, grant, capture and abandon decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_d     = 1'b0;
        w_capture     = 1'b0;
        w_abandon_nxt = r_abandon;
        case (r_state)
            S_IDLE: begin
                if (dmem_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (imem_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                if (!r_gnt_d && !imem_req) begin
                    w_abandon_nxt = 1'b1;
                end else begin
                    w_abandon_nxt = r_abandon;
                end
            end
            S_WAIT: begin
                // A fetch dropped in the capture cycle itself is still abandoned.
                if (!r_gnt_d && !imem_req) begin
                    w_abandon_nxt = 1'b1;
                end else begin
                    w_abandon_nxt = r_abandon;
                end
                if (r_cnt == 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, request registers, read-data capture and ready pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_gnt_d      <= 1'b0;
            r_abandon    <= 1'b0;
            r_imem_ready <= 1'b0;
            r_imem_rdata <= {XLEN{1'b0}};
            r_dmem_ready <= 1'b0;
            r_dmem_rdata <= {XLEN{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {XLEN{1'b0}};
            r_mem_wdata  <= {XLEN{1'b0}};
            r_mem_wmask  <= {(XLEN/8){1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_grant;
            r_dmem_ready <= w_capture & r_gnt_d;
            r_imem_ready <= w_capture & ~r_gnt_d & ~w_abandon_nxt;
            if (w_grant) begin
                r_gnt_d     <= w_grant_d;
                r_cnt       <= LAT_CNT;
                r_abandon   <= 1'b0;
                r_mem_we    <= w_grant_d & dmem_we;
                r_mem_addr  <= w_grant_d ? dmem_addr : imem_addr;
                r_mem_wdata <= w_grant_d ? dmem_wdata : {XLEN{1'b0}};
                r_mem_wmask <= w_grant_d ? dmem_wmask : {(XLEN/8){1'b0}};
            end else begin
                r_abandon <= w_abandon_nxt;
                if (r_state == S_WAIT) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_cnt <= r_cnt;
                end
            end
            if (w_capture && r_gnt_d && !r_mem_we) begin
                r_dmem_rdata <= mem_rdata;
            end else begin
                r_dmem_rdata <= r_dmem_rdata;
            end
            if (w_capture && !r_gnt_d && !w_abandon_nxt) begin
                r_imem_rdata <= mem_rdata;
            end else begin
                r_imem_rdata <= r_imem_rdata;
            end
        end
    end

    assign imem_ready = r_imem_ready;
    assign imem_rdata = r_imem_rdata;
    assign dmem_ready = r_dmem_ready;
    assign dmem_rdata = r_dmem_rdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wmask  = r_mem_wmask;
    assign MemStall   = (imem_req & ~r_imem_ready) | (dmem_req & ~r_dmem_ready);

endmodule
